icache_mshr_ctrl: RTL and testbench
===================================

// Module: icache_mshr_ctrl
// PURPOSE
//  Non-blocking I-cache miss controller between fetch and Imem, next to icache_mem.
//  Tracks up to N_MSHR outstanding line fills.
//  Issues demand misses for WAYS fetch ports and sequential prefetches PF_DEPTH lines ahead.
//  Suppresses requests for lines already in flight.
//  Routes each tagged memory response to the cache-mem write port.
// PARAMETERS
//  WAYS      2  fetch ports (8-byte line each)
//  N_MSHR    4  outstanding-fill entries, 1..15
//  PF_DEPTH  1  prefetch lines after port WAYS-1; 0 disables prefetch
//  IDX_W     5  set-index width, addr[IDX_W+2:3]
//  TAG_W     8  cache-tag width, addr[TAG_W+IDX_W+2:IDX_W+3]
// PORTS  (R = WAYS+PF_DEPTH read ports)
//  clock               in   1         system clock
//  reset               in   1         synchronous, active-high
//  proc2Icache_addr    in   WAYS*32   fetch addresses
//  proc2Icache_en      in   WAYS      fetch port active
//  prefetch_en         in   1         allow prefetch candidates
//  Imem2proc_response  in   4         nonzero = accepted, value is mem tag; 0 = rejected
//  Imem2proc_tag       in   4         tag of returning data; 0 = none
//  cachemem_data       in   R*64      lookup data per read port
//  cachemem_valid      in   R         lookup hit per read port
//  proc2Imem_command   out  2         BUS_NONE / BUS_LOAD
//  proc2Imem_addr      out  32        line address, [2:0]=0
//  Icache_data_out     out  WAYS*64   = cachemem_data[WAYS-1:0]
//  Icache_valid_out    out  WAYS      = cachemem_valid[WAYS-1:0]
//  rd_idx / rd_tag     out  R*IDX_W / R*TAG_W  lookup index/tag per read port
//  wr_idx / wr_tag     out  IDX_W / TAG_W      fill target
//  data_write_enable   out  1         fill cache-mem this cycle
//  mshr_full           out  1         all N_MSHR entries valid
//  outstanding         out  4         count of valid entries
// BEHAVIOUR
//  Read ports:
//   - Read port i<WAYS takes proc2Icache_addr[i].
//   - Prefetch port WAYS+k-1 (k=1..PF_DEPTH) takes line(addr[WAYS-1])+k, i.e. addr+8k mod 2^32.
//  Entry state (per entry): valid, mem_tag[3:0], line[31:3]. Reset clears all valid bits.
//  Candidates:
//   - Demand candidate: port i with en[i] & ~valid[i].
//   - Prefetch candidate: prefetch_en & en[WAYS-1] & ~valid[port].
//   - Any candidate whose line matches a registered valid entry is dropped.
//   - Priority: demand port 0 highest ... port WAYS-1, then prefetch k=1..PF_DEPTH.
//  Issue (combinational from registered state):
//   - If a candidate exists and ~mshr_full, drive BUS_LOAD with the winner's line address.
//   - Otherwise drive BUS_NONE, addr 0.
//   - One request per cycle.
//  Accept:
//   - If BUS_LOAD is driven and Imem2proc_response!=0, the lowest-index free entry
//     captures {response, line} at the clock edge.
//   - Response 0 allocates nothing; the request re-arbitrates next cycle, with no retry penalty.
//  Fill:
//   - When Imem2proc_tag!=0 and matches a valid entry's mem_tag:
//     data_write_enable=1 and wr_idx/wr_tag come from that entry, same cycle.
//   - That entry clears at the edge.
//   - No match: data_write_enable=0, no state change.
//   - When data_write_enable=0, wr_idx/wr_tag hold 0.
//  Simultaneous fill and accept:
//   - Both take effect.
//   - The freed entry is not reusable in the same cycle (free/full are computed pre-edge).
//   - outstanding stays unchanged.
//   - The completing line is still in the registered table, so it is never reissued that cycle.
//  Full: mshr_full=1 forces BUS_NONE; fills still drain normally.
//  Reset:
//   - Takes effect mid-flight; all entries are invalidated.
//   - Later responses carrying stale tags are ignored (no match).
//  Reset values:
//   - proc2Imem_command=BUS_NONE, proc2Imem_addr=0.
//   - data_write_enable=0, wr_idx=0, wr_tag=0.
//   - mshr_full=0, outstanding=0.
//  Latency:
//   - Miss to BUS_LOAD: 0 cycles (combinational).
//   - Tag return to data_write_enable: 0 cycles.
//   - Hits have no added latency.
// TESTING
//  1. Reset, en=2'b01, addr0=0x100, miss, response=3
//     -> BUS_LOAD addr 0x100; next cycle outstanding=1, no reissue of 0x100.
//  2. Imem2proc_tag=3 with entry {3,0x100}
//     -> data_write_enable=1, wr_idx=0, wr_tag=1, same cycle; outstanding=0 next.
//  3. Port0 and port1 both miss (0x200, 0x208), response=5 then 6
//     -> 0x200 issued first, then 0x208.
//  4. Fill N_MSHR=4 entries
//     -> mshr_full=1, BUS_NONE despite misses; fill tag frees an entry; next request issues the cycle after.
//  5. response=0 for 3 cycles then 7
//     -> same address re-driven each cycle; exactly one entry is allocated.
//  6. Prefetch: en[1]=1, addr1=0x3F8, prefetch_en=1, port hits, prefetch port misses
//     -> BUS_LOAD 0x400; addr1=0xFFFF_FFF8 wraps to prefetch 0x0.

Source files
------------

// File: rtl/icache_mshr_ctrl.sv
// Non-blocking I-cache miss controller: tracks outstanding line fills, issues demand
// and sequential prefetch misses, and steers tagged memory responses into the cache.
module icache_mshr_ctrl #(
  parameter int WAYS     = 2,
  parameter int N_MSHR   = 4,
  parameter int PF_DEPTH = 1,
  parameter int IDX_W    = 5,
  parameter int TAG_W    = 8,
  localparam int R       = WAYS + PF_DEPTH
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [WAYS*32-1:0]   proc2Icache_addr_i,
  input  logic [WAYS-1:0]      proc2Icache_en_i,
  input  logic                 prefetch_en_i,
  input  logic [3:0]           Imem2proc_response_i,
  input  logic [3:0]           Imem2proc_tag_i,
  input  logic [R*64-1:0]      cachemem_data_i,
  input  logic [R-1:0]         cachemem_valid_i,
  output logic [1:0]           proc2Imem_command_o,
  output logic [31:0]          proc2Imem_addr_o,
  output logic [WAYS*64-1:0]   Icache_data_out_o,
  output logic [WAYS-1:0]      Icache_valid_out_o,
  output logic [R*IDX_W-1:0]   rd_idx_o,
  output logic [R*TAG_W-1:0]   rd_tag_o,
  output logic [IDX_W-1:0]     wr_idx_o,
  output logic [TAG_W-1:0]     wr_tag_o,
  output logic                 data_write_enable_o,
  output logic                 mshr_full_o,
  output logic [3:0]           outstanding_o
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int LINE_W = 29;

  logic [N_MSHR-1:0] entryValid_q, entryValid_d;
  logic [3:0]        entryTag_q  [N_MSHR];
  logic [3:0]        entryTag_d  [N_MSHR];
  logic [LINE_W-1:0] entryLine_q [N_MSHR];
  logic [LINE_W-1:0] entryLine_d [N_MSHR];

  logic [LINE_W-1:0] portLine [R];
  logic [R-1:0]      portActive;
  logic [R-1:0]      portCand;
  logic              issueValid;
  logic [LINE_W-1:0] issueLine;
  logic              mshrFull;
  logic              accept;
  logic              allocFound;
  logic              fillFound;
  logic [N_MSHR-1:0] allocOh;
  logic [N_MSHR-1:0] fillOh;
  logic [LINE_W-1:0] fillLine;
  logic [3:0]        validCount;
  logic              unusedBits;

  assign Icache_data_out_o  = cachemem_data_i[WAYS*64-1:0];
  assign Icache_valid_out_o = cachemem_valid_i[WAYS-1:0];
  assign mshrFull           = &entryValid_q;
  assign mshr_full_o        = mshrFull;
  assign outstanding_o      = validCount;

  // Prefetch ports look sequentially ahead of the last fetch port, wrapping at 2^32.
  always_comb begin
    unusedBits = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      portLine[i]   = proc2Icache_addr_i[i*32+3 +: LINE_W];
      portActive[i] = proc2Icache_en_i[i];
      unusedBits    = unusedBits ^ (^proc2Icache_addr_i[i*32 +: 3]);
    end
    for (int k = WAYS; k < R; k++) begin
      portLine[k]   = proc2Icache_addr_i[(WAYS-1)*32+3 +: LINE_W] + LINE_W'(k - WAYS + 1);
      portActive[k] = prefetch_en_i & proc2Icache_en_i[WAYS-1];
      unusedBits    = unusedBits ^ (^cachemem_data_i[k*64 +: 64]);
    end
    for (int r = 0; r < R; r++) begin
      rd_idx_o[r*IDX_W +: IDX_W] = portLine[r][IDX_W-1:0];
      rd_tag_o[r*TAG_W +: TAG_W] = portLine[r][IDX_W +: TAG_W];
    end
  end

  // A miss becomes a candidate only if no registered entry already covers its line.
  always_comb begin
    portCand   = '0;
    issueValid = 1'b0;
    issueLine  = '0;
    for (int r = 0; r < R; r++) begin
      portCand[r] = portActive[r] & ~cachemem_valid_i[r];
      for (int e = 0; e < N_MSHR; e++) begin
        if (entryValid_q[e] && entryLine_q[e] == portLine[r]) portCand[r] = 1'b0;
      end
      if (portCand[r] && !issueValid) begin
        issueValid = 1'b1;
        issueLine  = portLine[r];
      end
    end
    proc2Imem_command_o = (issueValid && !mshrFull) ? BUS_LOAD : BUS_NONE;
    proc2Imem_addr_o    = (issueValid && !mshrFull) ? {issueLine, 3'b000} : 32'h0;
    accept              = (proc2Imem_command_o == BUS_LOAD) && (Imem2proc_response_i != 4'd0);
  end

  always_comb begin
    allocFound = 1'b0;
    fillFound  = 1'b0;
    allocOh    = '0;
    fillOh     = '0;
    fillLine   = '0;
    validCount = 4'd0;
    for (int e = 0; e < N_MSHR; e++) begin
      if (!entryValid_q[e] && !allocFound) begin
        allocFound = 1'b1;
        allocOh[e] = 1'b1;
      end
      if (entryValid_q[e] && Imem2proc_tag_i != 4'd0 && entryTag_q[e] == Imem2proc_tag_i
          && !fillFound) begin
        fillFound = 1'b1;
        fillOh[e] = 1'b1;
        fillLine  = entryLine_q[e];
      end
      if (entryValid_q[e]) validCount = validCount + 4'd1;
    end
    data_write_enable_o = fillFound;
    wr_idx_o            = fillLine[IDX_W-1:0];
    wr_tag_o            = fillLine[IDX_W +: TAG_W];
  end

  // Fill and accept always target different entries, so both may land in one edge.
  always_comb begin
    entryValid_d = entryValid_q;
    entryTag_d   = entryTag_q;
    entryLine_d  = entryLine_q;
    for (int e = 0; e < N_MSHR; e++) begin
      if (fillOh[e]) entryValid_d[e] = 1'b0;
      if (accept && allocOh[e]) begin
        entryValid_d[e] = 1'b1;
        entryTag_d[e]   = Imem2proc_response_i;
        entryLine_d[e]  = issueLine;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      entryValid_q <= '0;
      for (int e = 0; e < N_MSHR; e++) begin
        entryTag_q[e]  <= 4'd0;
        entryLine_q[e] <= '0;
      end
    end else begin
      entryValid_q <= entryValid_d;
      for (int e = 0; e < N_MSHR; e++) begin
        entryTag_q[e]  <= entryTag_d[e];
        entryLine_q[e] <= entryLine_d[e];
      end
    end
  end

endmodule

// File: tb/tb_icache_mshr_ctrl.sv
// Self-checking bench for icache_mshr_ctrl: directed scenarios plus a randomized run
// compared against a queue-based model of the outstanding-fill table.
module tb_icache_mshr_ctrl;

  localparam int WAYS = 2;
  localparam int N_MSHR = 4;
  localparam int PF_DEPTH = 1;
  localparam int R = WAYS + PF_DEPTH;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   addrBus = '0;
  logic [1:0]    en = '0;
  logic          prefetchEn = 1'b0;
  logic [3:0]    resp = '0;
  logic [3:0]    memTag = '0;
  logic [191:0]  cmData = '0;
  logic [2:0]    cmValid = '0;

  logic [1:0]    cmd;
  logic [31:0]   memAddr;
  logic [127:0]  dataOut;
  logic [1:0]    validOut;
  logic [14:0]   rdIdx;
  logic [23:0]   rdTag;
  logic [4:0]    wrIdx;
  logic [7:0]    wrTag;
  logic          we;
  logic          full;
  logic [3:0]    outst;

  int checks = 0;
  int errors = 0;

  // Model state: outstanding fills as parallel queues of memory tag and line byte address.
  logic [3:0]  qTag[$];
  logic [31:0] qAddr[$];
  logic [1:0]  expCmd;
  logic [31:0] expAddr;
  logic        expWe;
  logic [4:0]  expWrIdx;
  logic [7:0]  expWrTag;
  logic [3:0]  expOut;
  logic        expFull;
  int          fillPos;

  icache_mshr_ctrl #(.WAYS(WAYS), .N_MSHR(N_MSHR), .PF_DEPTH(PF_DEPTH), .IDX_W(5), .TAG_W(8)) dut (
    .clock_i(clock), .reset_i(reset),
    .proc2Icache_addr_i(addrBus), .proc2Icache_en_i(en), .prefetch_en_i(prefetchEn),
    .Imem2proc_response_i(resp), .Imem2proc_tag_i(memTag),
    .cachemem_data_i(cmData), .cachemem_valid_i(cmValid),
    .proc2Imem_command_o(cmd), .proc2Imem_addr_o(memAddr),
    .Icache_data_out_o(dataOut), .Icache_valid_out_o(validOut),
    .rd_idx_o(rdIdx), .rd_tag_o(rdTag), .wr_idx_o(wrIdx), .wr_tag_o(wrTag),
    .data_write_enable_o(we), .mshr_full_o(full), .outstanding_o(outst)
  );

  always #5 clock = ~clock;

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    en = '0; prefetchEn = 1'b0; resp = '0; memTag = '0; cmValid = '0;
    nextCycle();
    reset = 1'b0;
    qTag.delete();
    qAddr.delete();
  endtask

  // Expected outputs from the current inputs and the model's in-flight list.
  task automatic modelEval();
    logic [31:0] cand[$];
    logic [31:0] a;
    bit inFlight;
    expCmd = 2'd0; expAddr = 32'h0; expWe = 1'b0; expWrIdx = '0; expWrTag = '0;
    for (int i = 0; i < WAYS; i++)
      if (en[i] && !cmValid[i]) cand.push_back(addrBus[i*32 +: 32] & ~32'h7);
    for (int k = 1; k <= PF_DEPTH; k++)
      if (prefetchEn && en[WAYS-1] && !cmValid[WAYS+k-1])
        cand.push_back((addrBus[(WAYS-1)*32 +: 32] & ~32'h7) + 32'(8 * k));
    if (qAddr.size() < N_MSHR) begin
      foreach (cand[c]) begin
        a = cand[c];
        inFlight = 0;
        foreach (qAddr[q]) if (qAddr[q] == a) inFlight = 1;
        if (!inFlight && expCmd == 2'd0) begin
          expCmd = 2'd1;
          expAddr = a;
        end
      end
    end
    fillPos = -1;
    if (memTag != 0) foreach (qTag[q]) if (qTag[q] == memTag && fillPos < 0) fillPos = q;
    if (fillPos >= 0) begin
      expWe = 1'b1;
      expWrIdx = 5'((qAddr[fillPos] / 8) % 32);
      expWrTag = 8'((qAddr[fillPos] / 256) % 256);
    end
    expOut = 4'(qTag.size());
    expFull = (qTag.size() == N_MSHR);
  endtask

  task automatic modelCommit();
    if (fillPos >= 0) begin
      qTag.delete(fillPos);
      qAddr.delete(fillPos);
    end
    if (expCmd == 2'd1 && resp != 0) begin
      qTag.push_back(resp);
      qAddr.push_back(expAddr);
    end
  endtask

  task automatic test_reset();
    memTag = 4'd5;
    nextCycle();
    @(negedge clock);
    checks++;
    if ({cmd, memAddr} !== {2'd0, 32'h0}) begin
      errors++; $display("[TB] FAIL reset_bus: got cmd=%0d addr=%h, want 0/0", cmd, memAddr);
    end
    checks++;
    if ({we, wrIdx, wrTag, full, outst} !== 19'h0) begin
      errors++; $display("[TB] FAIL reset_state: got we=%b idx=%0d tag=%0d full=%b out=%0d, want all 0",
                         we, wrIdx, wrTag, full, outst);
    end
    reset = 1'b0;
    memTag = 4'd0;
    nextCycle();
  endtask

  task automatic test_single_miss_and_fill();
    doReset();
    en = 2'b01; addrBus = {32'h0, 32'h100}; cmValid = 3'b000; resp = 4'd3;
    @(negedge clock);
    checks++;
    if ({cmd, memAddr, outst} !== {2'd1, 32'h100, 4'd0}) begin
      errors++; $display("[TB] FAIL miss_issue: got cmd=%0d addr=%h out=%0d, want 1/100/0", cmd, memAddr, outst);
    end
    nextCycle();
    resp = 4'd0;
    @(negedge clock);
    checks++;
    if ({cmd, outst} !== {2'd0, 4'd1}) begin
      errors++; $display("[TB] FAIL miss_noreissue: got cmd=%0d out=%0d, want 0/1", cmd, outst);
    end
    nextCycle();
    memTag = 4'd3;
    @(negedge clock);
    checks++;
    if ({we, wrIdx, wrTag, cmd} !== {1'b1, 5'd0, 8'd1, 2'd0}) begin
      errors++; $display("[TB] FAIL fill_same_cycle: got we=%b idx=%0d tag=%0d cmd=%0d, want 1/0/1/0",
                         we, wrIdx, wrTag, cmd);
    end
    nextCycle();
    memTag = 4'd0; en = 2'b00;
    @(negedge clock);
    checks++;
    if ({we, wrIdx, wrTag, outst} !== {1'b0, 5'd0, 8'd0, 4'd0}) begin
      errors++; $display("[TB] FAIL fill_clear: got we=%b idx=%0d tag=%0d out=%0d, want 0/0/0/0",
                         we, wrIdx, wrTag, outst);
    end
    nextCycle();
  endtask

  task automatic test_priority_and_full();
    doReset();
    en = 2'b11; addrBus = {32'h208, 32'h200}; cmValid = 3'b000; resp = 4'd5;
    @(negedge clock);
    checks++;
    if ({cmd, memAddr} !== {2'd1, 32'h200}) begin
      errors++; $display("[TB] FAIL prio_first: got cmd=%0d addr=%h, want 1/200", cmd, memAddr);
    end
    nextCycle();
    resp = 4'd6;
    @(negedge clock);
    checks++;
    if ({cmd, memAddr, outst} !== {2'd1, 32'h208, 4'd1}) begin
      errors++; $display("[TB] FAIL prio_second: got cmd=%0d addr=%h out=%0d, want 1/208/1", cmd, memAddr, outst);
    end
    nextCycle();
    en = 2'b01; addrBus = {32'h208, 32'h300}; resp = 4'd8;
    nextCycle();
    addrBus = {32'h208, 32'h310}; resp = 4'd9;
    nextCycle();
    addrBus = {32'h208, 32'h320}; resp = 4'd10;
    @(negedge clock);
    checks++;
    if ({full, outst, cmd} !== {1'b1, 4'd4, 2'd0}) begin
      errors++; $display("[TB] FAIL full_block: got full=%b out=%0d cmd=%0d, want 1/4/0", full, outst, cmd);
    end
    nextCycle();
    memTag = 4'd8;
    @(negedge clock);
    checks++;
    if ({we, wrIdx, wrTag, cmd, full} !== {1'b1, 5'd0, 8'd3, 2'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL full_drain: got we=%b idx=%0d tag=%0d cmd=%0d full=%b, want 1/0/3/0/1",
                         we, wrIdx, wrTag, cmd, full);
    end
    nextCycle();
    memTag = 4'd0;
    @(negedge clock);
    checks++;
    if ({cmd, memAddr, full, outst} !== {2'd1, 32'h320, 1'b0, 4'd3}) begin
      errors++; $display("[TB] FAIL full_reissue: got cmd=%0d addr=%h full=%b out=%0d, want 1/320/0/3",
                         cmd, memAddr, full, outst);
    end
    nextCycle();
    resp = 4'd0;
    @(negedge clock);
    checks++;
    if ({full, outst} !== {1'b1, 4'd4}) begin
      errors++; $display("[TB] FAIL full_refill: got full=%b out=%0d, want 1/4", full, outst);
    end
    nextCycle();
  endtask

  task automatic test_retry();
    doReset();
    en = 2'b01; addrBus = {32'h0, 32'h500}; cmValid = 3'b000; resp = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if ({cmd, memAddr, outst} !== {2'd1, 32'h500, 4'd0}) begin
        errors++; $display("[TB] FAIL retry_%0d: got cmd=%0d addr=%h out=%0d, want 1/500/0", c, cmd, memAddr, outst);
      end
      nextCycle();
    end
    resp = 4'd7;
    @(negedge clock);
    checks++;
    if ({cmd, memAddr} !== {2'd1, 32'h500}) begin
      errors++; $display("[TB] FAIL retry_accept: got cmd=%0d addr=%h, want 1/500", cmd, memAddr);
    end
    nextCycle();
    resp = 4'd0;
    @(negedge clock);
    checks++;
    if ({cmd, outst} !== {2'd0, 4'd1}) begin
      errors++; $display("[TB] FAIL retry_single: got cmd=%0d out=%0d, want 0/1", cmd, outst);
    end
    nextCycle();
    memTag = 4'd7;
    @(negedge clock);
    checks++;
    if ({we, wrIdx, wrTag} !== {1'b1, 5'd0, 8'd5}) begin
      errors++; $display("[TB] FAIL retry_fill: got we=%b idx=%0d tag=%0d, want 1/0/5", we, wrIdx, wrTag);
    end
    nextCycle();
    memTag = 4'd0;
  endtask

  task automatic test_prefetch();
    doReset();
    en = 2'b10; addrBus = {32'h3F8, 32'h100}; prefetchEn = 1'b1; cmValid = 3'b011; resp = 4'd0;
    cmData = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clock);
    checks++;
    if ({cmd, memAddr} !== {2'd1, 32'h400}) begin
      errors++; $display("[TB] FAIL pf_issue: got cmd=%0d addr=%h, want 1/400", cmd, memAddr);
    end
    checks++;
    if ({rdIdx[14:10], rdTag[23:16], rdIdx[9:5], rdTag[15:8]} !== {5'd0, 8'd4, 5'd31, 8'd3}) begin
      errors++; $display("[TB] FAIL pf_lookup: got idx2=%0d tag2=%0d idx1=%0d tag1=%0d, want 0/4/31/3",
                         rdIdx[14:10], rdTag[23:16], rdIdx[9:5], rdTag[15:8]);
    end
    checks++;
    if ({validOut, dataOut} !== {cmValid[1:0], cmData[127:0]}) begin
      errors++; $display("[TB] FAIL passthru: got valid=%b data=%h", validOut, dataOut);
    end
    nextCycle();
    addrBus = {32'hFFFF_FFF8, 32'h100};
    @(negedge clock);
    checks++;
    if ({cmd, memAddr, rdTag[23:16]} !== {2'd1, 32'h0, 8'd0}) begin
      errors++; $display("[TB] FAIL pf_wrap: got cmd=%0d addr=%h tag2=%0d, want 1/0/0", cmd, memAddr, rdTag[23:16]);
    end
    nextCycle();
    prefetchEn = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd !== 2'd0) begin
      errors++; $display("[TB] FAIL pf_disabled: got cmd=%0d, want 0", cmd);
    end
    nextCycle();
    prefetchEn = 1'b1; cmValid = 3'b111;
    @(negedge clock);
    checks++;
    if (cmd !== 2'd0) begin
      errors++; $display("[TB] FAIL pf_hit: got cmd=%0d, want 0", cmd);
    end
    nextCycle();
  endtask

  task automatic test_reset_midflight();
    doReset();
    en = 2'b01; addrBus = {32'h0, 32'h600}; cmValid = 3'b000; resp = 4'd3;
    nextCycle();
    resp = 4'd0; en = 2'b00;
    doReset();
    memTag = 4'd3;
    @(negedge clock);
    checks++;
    if ({we, outst} !== {1'b0, 4'd0}) begin
      errors++; $display("[TB] FAIL stale_tag: got we=%b out=%0d, want 0/0", we, outst);
    end
    nextCycle();
    memTag = 4'd0;
  endtask

  task automatic test_random();
    logic [3:0] t;
    bit used;
    doReset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      en = 2'($urandom);
      prefetchEn = 1'($urandom);
      cmValid = 3'($urandom);
      cmData = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < WAYS; i++)
        addrBus[i*32 +: 32] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                              : 32'h1000 + 32'($urandom_range(0, 9)) * 8 + 32'($urandom_range(0, 7));
      resp = 4'd0;
      if ($urandom_range(0, 3) != 0) begin
        for (int tries = 0; tries < 20 && resp == 0; tries++) begin
          t = 4'($urandom_range(1, 15));
          used = 0;
          foreach (qTag[q]) if (qTag[q] == t) used = 1;
          if (!used) resp = t;
        end
      end
      memTag = 4'd0;
      if (qTag.size() != 0 && $urandom_range(0, 4) < 2) memTag = qTag[$urandom_range(0, qTag.size() - 1)];
      else if ($urandom_range(0, 4) == 0) memTag = 4'($urandom_range(1, 15));
      @(negedge clock);
      modelEval();
      checks++;
      if ({cmd, memAddr} !== {expCmd, expAddr}) begin
        errors++; $display("[TB] FAIL rand_issue c%0d: got cmd=%0d addr=%h, want %0d/%h", cyc, cmd, memAddr, expCmd, expAddr);
      end
      checks++;
      if ({we, wrIdx, wrTag} !== {expWe, expWrIdx, expWrTag}) begin
        errors++; $display("[TB] FAIL rand_fill c%0d: got we=%b idx=%0d tag=%0d, want %b/%0d/%0d",
                           cyc, we, wrIdx, wrTag, expWe, expWrIdx, expWrTag);
      end
      checks++;
      if ({full, outst} !== {expFull, expOut}) begin
        errors++; $display("[TB] FAIL rand_count c%0d: got full=%b out=%0d, want %b/%0d", cyc, full, outst, expFull, expOut);
      end
      modelCommit();
      nextCycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_miss_and_fill();
    test_priority_and_full();
    test_retry();
    test_prefetch();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
